// File: rtl/cp0_exception_ctrl_if.sv
// Bundle between the CP0 exception controller and its neighbours: the core
// (instruction-boundary handshake, PC redirect) and the single-port CP0 register file.
//   slave  : the controller side (takes core/CP0 inputs, drives CP0 port and redirect)
//   master : the core + CP0 register file side
interface cp0_exception_ctrl_if #(
  parameter int unsigned NUM_INT = 6
);
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic [NUM_INT-1:0] int_req;
  logic               instr_done;
  logic [DW-1:0]      next_pc;
  logic               eret_req;
  logic [DW-1:0]      cp0_dout;
  logic [RW-1:0]      cp0_regnum;
  logic [DW-1:0]      cp0_din;
  logic               cp0_wen;
  logic               cp0_busy;
  logic               pc_redirect;
  logic [DW-1:0]      redirect_pc;

  modport slave (
    input  int_req, instr_done, next_pc, eret_req, cp0_dout,
    output cp0_regnum, cp0_din, cp0_wen, cp0_busy, pc_redirect, redirect_pc
  );

  modport master (
    output int_req, instr_done, next_pc, eret_req, cp0_dout,
    input  cp0_regnum, cp0_din, cp0_wen, cp0_busy, pc_redirect, redirect_pc
  );
endinterface

// File: rtl/cp0_exception_ctrl.sv
// Interrupt entry / ERET exit sequencer for the multicycle MIPS core.
// Walks the single-port CP0 register file (Status=12, Cause=13, EPC=14) through
// read-modify-write steps while holding the core with cp0_busy, then pulses
// pc_redirect for one cycle with the target in redirect_pc.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       int_req/instr_done/next_pc/eret_req from the core,
//                     cp0_dout from CP0; drives cp0_regnum/cp0_din/cp0_wen,
//                     cp0_busy, pc_redirect, redirect_pc
module cp0_exception_ctrl #(
  parameter logic [31:0] VECTOR  = 32'h0000_4180,
  parameter int unsigned NUM_INT = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cp0_exception_ctrl_if.slave  bus
);

  localparam int unsigned DW     = 32;
  localparam int unsigned RW     = 5;
  localparam int unsigned IP_LSB = 10;

  localparam logic [RW-1:0] REG_STATUS = RW'(12);
  localparam logic [RW-1:0] REG_CAUSE  = RW'(13);
  localparam logic [RW-1:0] REG_EPC    = RW'(14);
  localparam logic [DW-1:0] EXL_MASK   = DW'(2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHK     = 3'd1,
    I_EPC   = 3'd2,
    I_CAUSE = 3'd3,
    I_ST    = 3'd4,
    E_ST    = 3'd5,
    E_EPC   = 3'd6,
    JUMP    = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_INT-1:0] ip_q, ip_d;
  logic [DW-1:0]      epc_q, epc_d;
  logic [DW-1:0]      redir_q, redir_d;

  logic [RW-1:0]      regnum_c;
  logic [DW-1:0]      din_c;
  logic               wen_c;
  logic               redirect_c;

  // Status fields seen through cp0_dout while Status is selected (CHK)
  logic               st_ie, st_exl, int_pending;

  assign st_ie       = bus.cp0_dout[0];
  assign st_exl      = bus.cp0_dout[1];
  assign int_pending = |(ip_q & bus.cp0_dout[IP_LSB +: NUM_INT]);

  // State and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ip_q    <= '0;
      epc_q   <= '0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      epc_q   <= epc_d;
      redir_q <= redir_d;
    end
  end

  // Next-state, capture and CP0 port decode
  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    epc_d      = epc_q;
    redir_d    = redir_q;
    regnum_c   = '0;
    din_c      = '0;
    wen_c      = 1'b0;
    redirect_c = 1'b0;

    case (state_q)
      IDLE: begin
        // ERET has priority over an interrupt arriving at the same boundary
        if (bus.instr_done) begin
          if (bus.eret_req) begin
            state_d = E_ST;
          end else if (|bus.int_req) begin
            ip_d    = bus.int_req;
            epc_d   = bus.next_pc;
            state_d = CHK;
          end
        end
      end
      CHK: begin
        // A rejected interrupt is simply dropped; it is re-sampled next boundary
        regnum_c = REG_STATUS;
        if (st_ie && !st_exl && int_pending) state_d = I_EPC;
        else                                 state_d = IDLE;
      end
      I_EPC: begin
        regnum_c = REG_EPC;
        wen_c    = 1'b1;
        din_c    = epc_q;
        state_d  = I_CAUSE;
      end
      I_CAUSE: begin
        // Cause holds the captured lines unmasked, ExcCode stays 0 (Int)
        regnum_c = REG_CAUSE;
        wen_c    = 1'b1;
        din_c    = DW'(ip_q) << IP_LSB;
        state_d  = I_ST;
      end
      I_ST: begin
        regnum_c = REG_STATUS;
        wen_c    = 1'b1;
        din_c    = bus.cp0_dout | EXL_MASK;
        redir_d  = VECTOR;
        state_d  = JUMP;
      end
      E_ST: begin
        regnum_c = REG_STATUS;
        wen_c    = 1'b1;
        din_c    = bus.cp0_dout & ~EXL_MASK;
        state_d  = E_EPC;
      end
      E_EPC: begin
        regnum_c = REG_EPC;
        redir_d  = bus.cp0_dout;
        state_d  = JUMP;
      end
      JUMP: begin
        redirect_c = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cp0_regnum  = regnum_c;
  assign bus.cp0_din     = din_c;
  assign bus.cp0_wen     = wen_c;
  assign bus.cp0_busy    = (state_q != IDLE);
  assign bus.pc_redirect = redirect_c;
  assign bus.redirect_pc = redir_q;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Bench for cp0_exception_ctrl: a CP0 register file stand-in plus a
// transaction-level reference model of interrupt entry / ERET exit.
module tb_cp0_exception_ctrl;

  localparam logic [31:0] VECTOR = 32'h0000_4180;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cp0_exception_ctrl_if #(.NUM_INT(6)) bus ();

  cp0_exception_ctrl #(.VECTOR(VECTOR), .NUM_INT(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // CP0 register file stand-in: combinational read, write on posedge.
  // Preloads go through the same process so the array has a single writer.
  logic [31:0] cp0_regs [32];
  logic        pre_en  = 1'b0;
  logic [4:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_en)           cp0_regs[pre_idx] <= pre_val;
    else if (bus.cp0_wen) cp0_regs[bus.cp0_regnum] <= bus.cp0_din;
  end

  assign bus.cp0_dout = cp0_regs[bus.cp0_regnum];

  // Reference model architectural state
  logic [31:0] ref_regs [32];

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input int idx, input logic [31:0] v);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = 5'(idx);
    pre_val = v;
    ref_regs[idx] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".status"}, cp0_regs[12], ref_regs[12]);
    check({tag, ".cause"},  cp0_regs[13], ref_regs[13]);
    check({tag, ".epc"},    cp0_regs[14], ref_regs[14]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"},     32'(bus.cp0_busy),    32'd0);
    check({tag, ".wen"},      32'(bus.cp0_wen),     32'd0);
    check({tag, ".regnum"},   32'(bus.cp0_regnum),  32'd0);
    check({tag, ".din"},      bus.cp0_din,          32'd0);
    check({tag, ".redirect"}, 32'(bus.pc_redirect), 32'd0);
  endtask

  // One instruction boundary: model predicts busy length, CP0 write count,
  // redirect timing/target and final CP0 contents.
  // drop=1 forces int_req low after capture, else it is scrambled randomly.
  task automatic run_txn(input string tag, input logic [5:0] ireq, input logic eret,
                         input logic [31:0] npc, input logic drop);
    int          exp_busy, exp_wr, exp_redir;
    logic [31:0] exp_pc;
    int          busy_cnt, wr_cnt, redir_at;
    logic [31:0] redir_pc;
    logic [31:0] st;

    st        = ref_regs[12];
    exp_busy  = 0;
    exp_wr    = 0;
    exp_redir = 0;
    exp_pc    = 32'd0;
    if (eret) begin
      exp_busy  = 3;
      exp_wr    = 1;
      exp_redir = 3;
      exp_pc    = ref_regs[14];
      ref_regs[12] = st & ~32'h2;
    end else if (ireq != 6'd0) begin
      if (st[0] && !st[1] && ((ireq & st[15:10]) != 6'd0)) begin
        exp_busy  = 5;
        exp_wr    = 3;
        exp_redir = 5;
        exp_pc    = VECTOR;
        ref_regs[14] = npc;
        ref_regs[13] = {16'h0, ireq, 10'h0};
        ref_regs[12] = st | 32'h2;
      end else begin
        exp_busy = 1;
      end
    end

    busy_cnt = 0;
    wr_cnt   = 0;
    redir_at = 0;
    redir_pc = 32'd0;

    @(negedge clk);
    bus.instr_done = 1'b1;
    bus.eret_req   = eret;
    bus.int_req    = ireq;
    bus.next_pc    = npc;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.instr_done = 1'b0;
      bus.eret_req   = 1'b0;
      bus.next_pc    = $urandom;
      bus.int_req    = drop ? 6'd0 : 6'($urandom);
      if (!bus.cp0_busy) break;
      busy_cnt++;
      if (bus.cp0_wen) wr_cnt++;
      if (bus.pc_redirect) begin
        redir_at = k;
        redir_pc = bus.redirect_pc;
      end
    end
    bus.int_req = 6'd0;

    check({tag, ".busy_cycles"},  32'(busy_cnt), 32'(exp_busy));
    check({tag, ".cp0_writes"},   32'(wr_cnt),   32'(exp_wr));
    check({tag, ".redirect_at"},  32'(redir_at), 32'(exp_redir));
    if (exp_redir != 0) check({tag, ".redirect_pc"}, redir_pc, exp_pc);
    check_regs(tag);
  endtask

  initial begin
    bus.int_req    = 6'd0;
    bus.instr_done = 1'b0;
    bus.eret_req   = 1'b0;
    bus.next_pc    = 32'd0;

    // Reset state
    #1;
    check_idle_outputs("reset");
    check("reset.redirect_pc", bus.redirect_pc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    set_reg(12, 32'd0);
    set_reg(13, 32'd0);
    set_reg(14, 32'd0);

    // Boundary with no request does nothing
    run_txn("noreq", 6'd0, 1'b0, 32'h0000_2000, 1'b0);

    // Take an interrupt, then return from it
    set_reg(12, 32'h0000_0401);
    run_txn("take", 6'b000001, 1'b0, 32'h0000_3010, 1'b0);
    check("take.status_abs", cp0_regs[12], 32'h0000_0403);
    check("take.cause_abs",  cp0_regs[13], 32'h0000_0400);
    run_txn("eret", 6'd0, 1'b1, 32'h0000_0000, 1'b0);
    check("eret.status_abs", cp0_regs[12], 32'h0000_0401);

    // Rejected: IE=0, IM=0, EXL=1
    set_reg(12, 32'h0000_0400);
    run_txn("rej_ie", 6'b000001, 1'b0, 32'h0000_5000, 1'b0);
    set_reg(12, 32'h0000_0001);
    run_txn("rej_im", 6'b000001, 1'b0, 32'h0000_5004, 1'b0);
    set_reg(12, 32'h0000_0403);
    run_txn("rej_exl", 6'b000001, 1'b0, 32'h0000_5008, 1'b0);

    // ERET wins over a simultaneous interrupt; interrupt taken next boundary
    set_reg(12, 32'h0000_8003);
    set_reg(14, 32'h0000_2000);
    run_txn("simul_eret", 6'b100000, 1'b1, 32'h0000_6000, 1'b0);
    run_txn("simul_int", 6'b100000, 1'b0, 32'h0000_6004, 1'b0);
    check("simul_int.cause_abs", cp0_regs[13], 32'h0000_8000);

    // Request dropped right after capture still completes with captured IP
    set_reg(12, 32'h0000_2401);
    run_txn("capture", 6'b001011, 1'b0, 32'h0000_7000, 1'b1);

    // Reset in the middle of I_CAUSE
    set_reg(12, 32'h0000_0401);
    set_reg(13, 32'h1234_0000);
    @(negedge clk);
    bus.instr_done = 1'b1;
    bus.int_req    = 6'b000001;
    bus.next_pc    = 32'h0000_5000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.instr_done = 1'b0;
      bus.next_pc    = 32'd0;
    end
    check("rst_mid.in_cause_wen",    32'(bus.cp0_wen),    32'd1);
    check("rst_mid.in_cause_regnum", 32'(bus.cp0_regnum), 32'd13);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_mid.redirect_pc", bus.redirect_pc, 32'd0);
    ref_regs[14] = 32'h0000_5000;
    bus.int_req  = 6'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_after");
    check_regs("rst_after");

    // Randomized boundaries against the model
    for (int t = 0; t < 80; t++) begin
      if (($urandom % 3) == 0) set_reg(12, $urandom);
      if (($urandom % 6) == 0) set_reg(14, $urandom & 32'hFFFF_FFFC);
      run_txn($sformatf("rnd%0d", t),
              (($urandom % 4) == 0) ? 6'd0 : 6'($urandom),
              (($urandom % 4) == 0),
              $urandom & 32'hFFFF_FFFC,
              1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
